spi_slave_frontend: RTL and testbench
=====================================

Name: spi_slave_frontend

Overview:
SPI mode-0 slave front end for the TinyTapeout SPI slave top.
- Oversamples SCK, CS_N and MOSI in the system clock domain and deserialises MOSI bytes, MSB first.
- Serialises a buffered transmit byte onto MISO.
- Feeds received bytes into the downstream register/counter logic as one-cycle valid strobes.
- Takes response bytes back from that logic through a single-entry transmit buffer.

Parameters:
DATA_W, 8, bits per SPI word and width of rx_data/tx_data.
SYNC_STAGES, 2, flip-flop stages on each SPI input. Minimum 2.

Ports:
clk  input  1  system clock; must run at least 4x the SCK frequency.
rst_n  input  1  asynchronous active-low reset.
spi_sck  input  1  SPI clock from master, CPOL=0. Asynchronous to clk.
spi_cs_n  input  1  SPI chip select, active low. Asynchronous.
spi_mosi  input  1  master-out data. Asynchronous.
spi_miso  output  1  slave-out data, equal to tx_shift[DATA_W-1].
spi_miso_oe  output  1  MISO pad output enable; high while CS is synchronised-asserted.
rx_data  output  DATA_W  last complete received word. Held until the next word completes.
rx_valid  output  1  one-cycle strobe; rx_data is new in this cycle.
tx_data  input  DATA_W  response word to transmit.
tx_load  input  1  writes tx_data into the transmit buffer if tx_ready=1.
tx_ready  output  1  transmit buffer empty.
frame_err  output  1  one-cycle strobe on CS deassert with a partial word.
busy  output  1  state is SHIFT.

Behaviour:
Clock and reset:
- One clock domain (clk). rst_n is asynchronous active-low.
- On reset all outputs and internal state are zero, with two exceptions: tx_ready=1 and state=IDLE.
- Zeroed state includes rx_data=0, rx_valid=0, frame_err=0, spi_miso=0, spi_miso_oe=0, bit_cnt=0, tx_shift=0.

Input synchronisation:
- Each SPI input passes through SYNC_STAGES flip-flops, plus one extra flip-flop on SCK and CS_N for edge detection.
- sck_rise = sync high and previous low; sck_fall = the opposite.
- cs_fall / cs_rise are detected the same way on CS_N.
- Any pin edge becomes visible SYNC_STAGES+1 clk cycles after it occurs.

States: IDLE, SHIFT.
- IDLE -> SHIFT on cs_fall.
  - tx_shift loads the buffered byte if the buffer is full, else 0x00. The buffer is consumed and tx_ready is set to 1.
  - bit_cnt is set to 0.
- SHIFT, on sck_rise:
  - rx_shift <= {rx_shift[DATA_W-2:0], mosi_sync}.
  - bit_cnt increments modulo DATA_W.
  - When bit_cnt wraps from DATA_W-1 to 0: rx_data <= completed word and rx_valid=1 in the next cycle, exactly one cycle wide.
- SHIFT, on sck_fall:
  - If bit_cnt != 0: tx_shift shifts left by 1, filling with 0.
  - If bit_cnt == 0 (word boundary): tx_shift reloads from the buffer, or 0x00 on underrun, and the buffer is consumed. This supports multi-word frames with no CS gap.
- SHIFT -> IDLE on cs_rise.
  - If bit_cnt != 0: frame_err=1 for one cycle, no rx_valid is issued, and the partial word is discarded.
  - bit_cnt clears and tx_shift clears.

Transmit buffer:
- Single entry.
- tx_load with tx_ready=1: stores tx_data and tx_ready goes to 0 the next cycle.
- tx_load with tx_ready=0: ignored; buffer contents are unchanged.
- tx_load in the same cycle as a consume: the consume takes the old contents, the new tx_data is stored, and tx_ready stays 0.

Edge-case rules:
- SCK edges while in IDLE are ignored.
- A cs_fall in the same cycle as an SCK edge: the CS action takes priority and the SCK edge is dropped. Masters must respect CS setup time.
- spi_miso_oe = inverse of the synchronised CS_N, with no combinational path from the pin.
- Reset asserted mid-frame: returns immediately to the reset values. After release, the block waits in IDLE for a fresh cs_fall, even if CS is already low.

Test Plan:
1. Preload 0x3C (tx_load while tx_ready=1), then one 8-bit frame sending MOSI 0xA5 at SCK=clk/8:
   - MISO shifts out 0x3C, MSB first, valid on every SCK rising edge.
   - rx_valid pulses once with rx_data=0xA5 within 4 clk cycles of the 8th SCK rise.
   - tx_ready=1 after CS falls.
2. Two-word frame with no CS gap; preload 0x11, then load 0x22 while the first word is shifting; MOSI 0xDE 0xAD:
   - MISO outputs 0x11 then 0x22.
   - rx_valid pulses twice, with rx_data=0xDE then 0xAD.
3. Underrun: buffer empty at CS fall, MOSI 0xFF:
   - MISO outputs 0x00.
   - rx_data=0xFF with a single rx_valid.
4. Abort: CS rises after 5 SCK rises:
   - frame_err pulses once, with no rx_valid.
   - The next full frame sending 0x5A yields rx_data=0x5A.
5. Buffer overflow: tx_load 0x77, then tx_load 0x88 while tx_ready=0:
   - The next frame shifts out 0x77, not 0x88.
6. Reset mid-frame: assert rst_n=0 after 3 SCK rises, release it while CS is still low:
   - All outputs return to reset values, with busy=0.
   - No rx_valid until CS rises and falls again.

Source files
------------

// File: rtl/spi_slave_frontend.sv
// spi_slave_frontend
// SPI mode-0 (CPOL=0, CPHA=0) slave front end running in the system clock
// domain. SCK, CS_N and MOSI are oversampled through synchroniser chains.
// MOSI words are deserialised MSB first, and a single-entry transmit buffer
// feeds the MISO shifter.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   spi_sck/cs_n/mosi     asynchronous SPI pins from the master
//   spi_miso, spi_miso_oe slave data out and its pad enable
//   rx_data, rx_valid     received word and its one-cycle strobe
//   tx_data, tx_load      response word write port (accepted when tx_ready)
//   tx_ready              transmit buffer empty
//   frame_err             one-cycle strobe on CS release mid-word
//   busy                  a frame is in progress (state SHIFT)
module spi_slave_frontend #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync_chain;
  logic                   sck_prev, cs_prev;
  logic                   sck_s, cs_s, mosi_sync;
  logic                   sck_rise, sck_fall, cs_fall, cs_rise;

  logic [DATA_W-1:0]      rx_shift, tx_shift, tx_buf;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   consume, load_ok;
  logic [DATA_W-1:0]      consume_word;

  // Synchronisers. The CS chain resets to 0 (asserted) so that a CS already
  // low when reset releases never produces a cs_fall: the block then waits
  // for a fresh CS assertion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync        <= '0;
      cs_sync         <= '0;
      mosi_sync_chain <= '0;
      sck_prev        <= 1'b0;
      cs_prev         <= 1'b0;
    end else begin
      sck_sync        <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync         <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_chain <= {mosi_sync_chain[SYNC_STAGES-2:0], spi_mosi};
      sck_prev        <= sck_sync[SYNC_STAGES-1];
      cs_prev         <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_sync = mosi_sync_chain[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_prev;
  assign sck_fall  = ~sck_s & sck_prev;
  assign cs_fall   = ~cs_s & cs_prev;
  assign cs_rise   = cs_s & ~cs_prev;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cs_fall) state_next = SHIFT;
      SHIFT:   if (cs_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state == SHIFT);
  end

  // The buffer is consumed at frame start and at every word boundary on the
  // falling SCK edge (bit_cnt back at 0), so back-to-back words need no CS gap.
  assign consume = ((state == IDLE) && cs_fall) ||
                   ((state == SHIFT) && !cs_rise && sck_fall && (bit_cnt == '0));
  assign consume_word = tx_ready ? '0 : tx_buf;
  // A load that coincides with a consume is accepted even with the buffer full:
  // the consume takes the old word and the new one takes its place.
  assign load_ok = tx_load && (tx_ready || consume);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_buf   <= '0;
      tx_ready <= 1'b1;
    end else if (load_ok) begin
      tx_buf   <= tx_data;
      tx_ready <= 1'b0;
    end else if (consume) begin
      tx_ready <= 1'b1;
    end
  end

  // Shift datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift    <= '0;
      tx_shift    <= '0;
      bit_cnt     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      spi_miso_oe <= ~cs_s;
      if (state == IDLE) begin
        if (cs_fall) begin
          tx_shift <= consume_word;
          bit_cnt  <= '0;
        end
      end else if (cs_rise) begin
        // A partial word is dropped; only the error strobe reports it.
        frame_err <= (bit_cnt != '0);
        bit_cnt   <= '0;
        tx_shift  <= '0;
      end else if (sck_rise) begin
        rx_shift <= {rx_shift[DATA_W-2:0], mosi_sync};
        if (bit_cnt == LAST_BIT) begin
          bit_cnt  <= '0;
          rx_data  <= {rx_shift[DATA_W-2:0], mosi_sync};
          rx_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (sck_fall) begin
        if (bit_cnt == '0) tx_shift <= consume_word;
        else               tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign spi_miso = tx_shift[DATA_W-1];

endmodule

// File: tb/tb_spi_slave_frontend.sv
module tb_spi_slave_frontend;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sck = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_ready, frame_err, busy;

  int tests = 0;
  int fails = 0;

  // Monitor-owned observations (written only here, read by the stimulus).
  int         rx_cnt = 0;
  int         ferr_cnt = 0;
  logic [7:0] rx_last = 8'h00;
  logic [7:0] rx_prev = 8'h00;
  time        rx_time = 0;
  time        last_rise = 0;

  spi_slave_frontend #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt  <= rx_cnt + 1;
      rx_prev <= rx_last;
      rx_last <= rx_data;
      rx_time <= $time;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    wait_clk(1);
    tx_load = 1'b0;
    wait_clk(1);
  endtask

  task automatic cs_down();
    spi_cs_n = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_up();
    spi_cs_n = 1'b1;
    wait_clk(6);
  endtask

  // SCK = clk/8; MISO is sampled just before each rising SCK edge.
  task automatic send_bits(input logic [7:0] m, input int nbits, output logic [7:0] cap);
    cap = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = m[7-i];
      wait_clk(4);
      cap = {cap[6:0], spi_miso};
      spi_sck = 1'b1;
      last_rise = $time;
      wait_clk(4);
      spi_sck = 1'b0;
    end
    wait_clk(4);
  endtask

  initial begin
    logic [7:0] cap;
    int rx0, fe0;

    // Reset state
    wait_clk(3);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_miso", spi_miso, 1'b0);
    check("rst_miso_oe", spi_miso_oe, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    rst_n = 1'b1;
    wait_clk(6);

    // 1: preload 0x3C, single word, MOSI 0xA5
    load(8'h3C);
    check("t1_ready_after_load", tx_ready, 1'b0);
    rx0 = rx_cnt; fe0 = ferr_cnt;
    cs_down();
    check("t1_ready_after_cs", tx_ready, 1'b1);
    check("t1_busy", busy, 1'b1);
    check("t1_miso_oe", spi_miso_oe, 1'b1);
    send_bits(8'hA5, 8, cap);
    check("t1_miso", cap, 8'h3C);
    check("t1_rx_cnt", rx_cnt - rx0, 1);
    check("t1_rx_data", rx_last, 8'hA5);
    check("t1_rx_latency_le40ns", ((rx_time - last_rise) <= 40) ? 1 : 0, 1);
    cs_up();
    check("t1_busy_end", busy, 1'b0);
    check("t1_no_ferr", ferr_cnt - fe0, 0);

    // 2: two words without CS gap
    load(8'h11);
    rx0 = rx_cnt;
    cs_down();
    load(8'h22);
    send_bits(8'hDE, 8, cap);
    check("t2_miso_w0", cap, 8'h11);
    send_bits(8'hAD, 8, cap);
    check("t2_miso_w1", cap, 8'h22);
    cs_up();
    check("t2_rx_cnt", rx_cnt - rx0, 2);
    check("t2_rx_w0", rx_prev, 8'hDE);
    check("t2_rx_w1", rx_last, 8'hAD);

    // 3: underrun
    rx0 = rx_cnt;
    cs_down();
    send_bits(8'hFF, 8, cap);
    cs_up();
    check("t3_miso", cap, 8'h00);
    check("t3_rx_cnt", rx_cnt - rx0, 1);
    check("t3_rx_data", rx_last, 8'hFF);

    // 4: abort after 5 bits, then a clean frame
    rx0 = rx_cnt; fe0 = ferr_cnt;
    cs_down();
    send_bits(8'hF0, 5, cap);
    cs_up();
    check("t4_ferr_cnt", ferr_cnt - fe0, 1);
    check("t4_no_rx", rx_cnt - rx0, 0);
    cs_down();
    send_bits(8'h5A, 8, cap);
    cs_up();
    check("t4_rx_cnt", rx_cnt - rx0, 1);
    check("t4_rx_data", rx_last, 8'h5A);

    // 5: overflow load ignored
    load(8'h77);
    load(8'h88);
    check("t5_ready", tx_ready, 1'b0);
    cs_down();
    send_bits(8'h00, 8, cap);
    cs_up();
    check("t5_miso", cap, 8'h77);

    // 6: reset mid-frame, released with CS still low
    load(8'h3C);
    cs_down();
    send_bits(8'hC3, 3, cap);
    rst_n = 1'b0;
    wait_clk(2);
    check("t6_busy", busy, 1'b0);
    check("t6_rx_data", rx_data, 8'h00);
    check("t6_tx_ready", tx_ready, 1'b1);
    check("t6_miso", spi_miso, 1'b0);
    check("t6_miso_oe", spi_miso_oe, 1'b0);
    rst_n = 1'b1;
    wait_clk(4);
    rx0 = rx_cnt;
    send_bits(8'hFF, 8, cap);
    check("t6_no_rx_cs_low", rx_cnt - rx0, 0);
    check("t6_idle_cs_low", busy, 1'b0);
    cs_up();
    cs_down();
    send_bits(8'h96, 8, cap);
    cs_up();
    check("t6_rx_cnt_after", rx_cnt - rx0, 1);
    check("t6_rx_data_after", rx_last, 8'h96);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
